// File: rtl/sequencer_pkg.sv
// Shared types and constants for the sequence-memory arbiter: FSM states,
// default geometry, the out-of-range read word and the one-hot grant encoding.
package sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RWAIT,
    RDONE
  } state_e;

  localparam int WORD_SIZE_DEF    = 2;
  localparam int ADDRESS_SIZE_DEF = 4;
  localparam int MEMORY_QTY_DEF   = 16;
  localparam logic [1:0] WORD_INIT_DEF = 2'b10;

  // Request/grant bit positions: bit 0 is the store (write), bit 1 the sequencer (read)
  localparam int REQ_W = 0;
  localparam int REQ_R = 1;
  localparam logic [1:0] GRANT_WRITE = 2'b01;
  localparam logic [1:0] GRANT_READ  = 2'b10;

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant between write (bit 0) and read (bit 1) requesters.
// Round-robin by default; WRITE_PRIORITY_EN makes the write win every contest.
module arb_rr2
  import sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef WRITE_PRIORITY_EN
  logic unused_ok;
  assign unused_ok = clock ^ reset ^ advance;

  always_comb begin
    grant = '0;
    if (req[REQ_W])      grant = GRANT_WRITE;
    else if (req[REQ_R]) grant = GRANT_READ;
  end
`else
  // rr_last_q = 1 when the most recent grant went to the read
  logic rr_last_q, rr_last_d;

  always_comb begin
    grant = '0;
    if (req[REQ_W] && (!req[REQ_R] || rr_last_q)) grant = GRANT_WRITE;
    else if (req[REQ_R])                          grant = GRANT_READ;
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (advance && (grant != '0)) rr_last_d = (grant == GRANT_READ);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rr_last_q <= 1'b1;
    else        rr_last_q <= rr_last_d;
  end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port sequence memory between the store (write) and the
// sequencer (read). Build with WRITE_PRIORITY_EN to give writes strict priority.
module memory_arbiter
  import sequencer_pkg::*;
#(
  parameter int                   WORD_SIZE    = WORD_SIZE_DEF,
  parameter int                   ADDRESS_SIZE = ADDRESS_SIZE_DEF,
  parameter int                   MEMORY_QTY   = MEMORY_QTY_DEF,
  parameter logic [WORD_SIZE-1:0] WORD_INIT    = WORD_INIT_DEF,
  parameter int                   READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    w_req,
  input  logic [ADDRESS_SIZE-1:0] w_addr,
  input  logic [WORD_SIZE-1:0]    w_data,
  output logic                    w_ready,
  input  logic                    r_req,
  input  logic [ADDRESS_SIZE-1:0] r_addr,
  output logic                    r_ready,
  output logic [WORD_SIZE-1:0]    r_data,
  output logic                    m_en,
  output logic                    m_we,
  output logic [ADDRESS_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0]    m_wdata,
  input  logic [WORD_SIZE-1:0]    m_rdata,
  output logic                    busy
);

  localparam int CNT_W = 2;
  localparam logic [ADDRESS_SIZE:0] QTY = (ADDRESS_SIZE+1)'(MEMORY_QTY);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    oor_q, oor_d;
  logic                    m_en_q, m_en_d, m_we_q, m_we_d;
  logic [ADDRESS_SIZE-1:0] m_addr_q, m_addr_d;
  logic [WORD_SIZE-1:0]    m_wdata_q, m_wdata_d;
  logic                    w_ready_q, w_ready_d, r_ready_q, r_ready_d;
  logic [WORD_SIZE-1:0]    r_data_q, r_data_d;
  logic                    busy_q, busy_d;

  logic [1:0] req, grant;
  logic       advance;
  logic       w_in_range, r_in_range;

  assign w_in_range = {1'b0, w_addr} < QTY;
  assign r_in_range = {1'b0, r_addr} < QTY;

  always_comb begin
    req        = '0;
    req[REQ_W] = w_req;
    req[REQ_R] = r_req;
  end

  arb_rr2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  // Every output is a flop loaded with the value it must show in the next state,
  // so addr/data are sampled once, at grant.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    oor_d     = oor_q;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    w_ready_d = 1'b0;
    r_ready_d = 1'b0;
    r_data_d  = r_data_q;
    advance   = 1'b0;
    unique case (state_q)
      IDLE: begin
        advance = 1'b1;
        if (grant == GRANT_WRITE) begin
          state_d   = WRITE;
          m_en_d    = w_in_range;
          m_we_d    = 1'b1;
          m_addr_d  = w_addr;
          m_wdata_d = w_data;
          w_ready_d = 1'b1;
        end else if (grant == GRANT_READ) begin
          state_d  = READ;
          m_en_d   = r_in_range;
          m_addr_d = r_addr;
          oor_d    = !r_in_range;
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        state_d = RWAIT;
        cnt_d   = CNT_W'(READ_LATENCY - 1);
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          state_d   = RDONE;
          r_ready_d = 1'b1;
          r_data_d  = oor_q ? WORD_INIT : m_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      oor_q     <= 1'b0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      w_ready_q <= 1'b0;
      r_ready_q <= 1'b0;
      r_data_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      oor_q     <= oor_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      w_ready_q <= w_ready_d;
      r_ready_q <= r_ready_d;
      r_data_q  <= r_data_d;
      busy_q    <= busy_d;
    end
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign w_ready = w_ready_q;
  assign r_ready = r_ready_q;
  assign r_data  = r_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: behavioural memory with read latency, completion
// monitor feeding an observed queue, tasks pushing expected completions.
module tb_memory_arbiter;

  localparam int AW  = 4;
  localparam int DW  = 2;
  localparam int QTY = 12;
  localparam int LAT = 3;
  localparam logic [DW-1:0] INIT = 2'b10;

  typedef struct packed {
    logic          wr;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } ev_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          w_req = 1'b0, r_req = 1'b0;
  logic [AW-1:0] w_addr = '0, r_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          w_ready, r_ready, m_en, m_we, busy;
  logic [DW-1:0] r_data, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;

  int  cyc = 0;
  int  checks = 0;
  int  passes = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  logic [DW-1:0] model [16];

  memory_arbiter #(
    .WORD_SIZE(DW), .ADDRESS_SIZE(AW), .MEMORY_QTY(QTY),
    .WORD_INIT(INIT), .READ_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
    .r_req(r_req), .r_addr(r_addr), .r_ready(r_ready), .r_data(r_data),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory: read data is valid only LAT cycles after a read enable, X otherwise
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clock) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    rd_pipe[0] <= (m_en && !m_we) ? mem[m_addr] : 'x;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m_rdata = rd_pipe[LAT-1];

  always @(negedge clock) begin
    if (w_ready) obs_q.push_back('{wr: 1'b1, en: m_en, we: m_we, addr: m_addr, data: m_wdata, cyc: 32'(cyc)});
    if (r_ready) obs_q.push_back('{wr: 1'b0, en: 1'b0, we: 1'b0, addr: '0, data: r_data, cyc: 32'(cyc)});
  end

  function automatic ev_t ev_w(logic [AW-1:0] a, logic [DW-1:0] d, int c);
    return '{wr: 1'b1, en: (int'(a) < QTY), we: 1'b1, addr: a, data: d, cyc: 32'(c)};
  endfunction

  function automatic ev_t ev_r(logic [AW-1:0] a, int c);
    return '{wr: 1'b0, en: 1'b0, we: 1'b0, addr: '0,
             data: (int'(a) < QTY) ? model[a] : INIT, cyc: 32'(c)};
  endfunction

  // Waits for n ready pulses (bounded), then drops both requests on that ready cycle
  task automatic wait_ready(input int n, output int got);
    got = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      @(negedge clock);
      if (w_ready) got++;
      if (r_ready) got++;
    end
    w_req = 1'b0;
    r_req = 1'b0;
    #1;
  endtask

  task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int t0);
    @(posedge clock); #1;
    t0 = cyc; w_addr = a; w_data = d; w_req = 1'b1;
    if (int'(a) < QTY) model[a] = d;
  endtask

  task automatic start_read(input logic [AW-1:0] a, output int t0);
    @(posedge clock); #1;
    t0 = cyc; r_addr = a; r_req = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy, m_en, w_ready, r_ready, r_data} !== '0)
      $display("FAIL reset_hold: busy=%b m_en=%b w_ready=%b r_ready=%b r_data=%b, required all 0",
               busy, m_en, w_ready, r_ready, r_data);
    else passes++;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if ({busy, m_en, w_ready, r_ready, r_data} !== '0)
        $display("FAIL reset_idle cycle %0d: busy=%b m_en=%b w_ready=%b r_ready=%b r_data=%b, required all 0",
                 i, busy, m_en, w_ready, r_ready, r_data);
      else passes++;
    end
  endtask

  task automatic test_write_read();
    int t0, got;
    ev_t e, o;
    start_write(4'd3, 2'b01, t0);
    exp_q.push_back(ev_w(4'd3, 2'b01, t0 + 1));
    wait_ready(1, got);
    start_read(4'd3, t0);
    exp_q.push_back(ev_r(4'd3, t0 + LAT + 2));
    wait_ready(1, got);
    // a later write must leave r_data untouched
    start_write(4'd7, 2'b11, t0);
    exp_q.push_back(ev_w(4'd7, 2'b11, t0 + 1));
    wait_ready(1, got);
    checks++;
    if (r_data !== 2'b01) $display("FAIL rdata_hold: r_data=%b, required 01", r_data);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL write_read: no completion, required %p", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL write_read: got %p, required %p", o, e);
        else passes++;
      end
    end
  endtask

  task automatic test_contest();
    int t0, got;
    ev_t e, o;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    t0 = cyc; w_addr = 4'd5; w_data = 2'b10; r_addr = 4'd5;
    w_req = 1'b1; r_req = 1'b1;
    model[5] = 2'b10;
`ifdef WRITE_PRIORITY_EN
    exp_q.push_back(ev_w(4'd5, 2'b10, t0 + 1));
    exp_q.push_back(ev_w(4'd5, 2'b10, t0 + 3));
    exp_q.push_back(ev_w(4'd5, 2'b10, t0 + 5));
    exp_q.push_back(ev_w(4'd5, 2'b10, t0 + 7));
`else
    exp_q.push_back(ev_w(4'd5, 2'b10, t0 + 1));
    exp_q.push_back(ev_r(4'd5, t0 + 2 + LAT + 2));
    exp_q.push_back(ev_w(4'd5, 2'b10, t0 + 2 + LAT + 2 + 2));
    exp_q.push_back(ev_r(4'd5, t0 + 2 * (2 + LAT + 2) + 1));
`endif
    wait_ready(4, got);
    checks++;
    if (got !== 4) $display("FAIL contest_done: %0d completions, required 4", got);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL contest_order: no completion, required %p", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL contest_order: got %p, required %p", o, e);
        else passes++;
      end
    end
  endtask

  task automatic test_out_of_range();
    int t0, got;
    ev_t e, o;
    logic [AW-1:0] wa [3];
    logic [DW-1:0] wd [3];
    wa = '{4'd11, 4'd12, 4'd13};
    wd = '{2'b11, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      start_write(wa[i], wd[i], t0);
      exp_q.push_back(ev_w(wa[i], wd[i], t0 + 1));
      wait_ready(1, got);
    end
    for (int i = 0; i < 3; i++) begin
      start_read(wa[i], t0);
      exp_q.push_back(ev_r(wa[i], t0 + LAT + 2));
      wait_ready(1, got);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL out_of_range: no completion, required %p", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL out_of_range: got %p, required %p", o, e);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_rwait();
    int t0, got;
    ev_t e, o;
    start_read(4'd3, t0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    r_req = 1'b0;
    #1;
    checks++;
    if ({busy, m_en, r_ready, r_data} !== '0)
      $display("FAIL rwait_reset: busy=%b m_en=%b r_ready=%b r_data=%b, required all 0",
               busy, m_en, r_ready, r_data);
    else passes++;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (10) @(negedge clock);
    #1;
    checks++;
    if (obs_q.size() !== 0) $display("FAIL rwait_abandon: %0d completions, required 0", obs_q.size());
    else passes++;
    obs_q.delete();
    start_read(4'd3, t0);
    exp_q.push_back(ev_r(4'd3, t0 + LAT + 2));
    wait_ready(1, got);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) $display("FAIL rwait_fresh: no completion, required %p", e);
    else begin
      o = obs_q.pop_front();
      if (o !== e) $display("FAIL rwait_fresh: got %p, required %p", o, e);
      else passes++;
    end
  endtask

  task automatic test_random();
    int t0, got;
    ev_t e, o;
    logic [AW-1:0] a;
    for (int i = 0; i < QTY; i++) begin
      start_write(AW'(i), DW'($urandom_range(0, 3)), t0);
      exp_q.push_back(ev_w(AW'(i), model[i], t0 + 1));
      wait_ready(1, got);
    end
    for (int i = 0; i < 24; i++) begin
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        start_write(a, DW'($urandom_range(0, 3)), t0);
        exp_q.push_back(ev_w(a, w_data, t0 + 1));
      end else begin
        start_read(a, t0);
        exp_q.push_back(ev_r(a, t0 + LAT + 2));
      end
      wait_ready(1, got);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL random: no completion, required %p", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL random: got %p, required %p", o, e);
        else passes++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    test_reset();
    test_write_read();
    test_contest();
    test_out_of_range();
    test_reset_rwait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
